// File: rtl/cic_pkg.sv
// cic_pkg: shared widths and channel encoding for the CIC transmit path
package cic_pkg;
  localparam int DW = 18;
  localparam int AW = 4;
  localparam logic CH_A = 1'b1;
  localparam logic CH_B = 1'b0;
endpackage

// File: rtl/tx_fifo.sv
// tx_fifo: one-channel sample-pair FIFO with a registered pop hold and per-channel flag pulses
module tx_fifo import cic_pkg::*; #(
  parameter int W = 2 * DW,
  parameter int A = AW
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wd,
  output logic [W-1:0] rd,
  output logic [A:0]   lvl,
  output logic         full,
  output logic         ovf_set,
  output logic         unf_set
);
  logic [W-1:0] mem [2**A];
  logic [A:0]   wp_q, wp_d, rp_q, rp_d;
  logic [W-1:0] rd_q, rd_d;
  logic         empty, push_ok, pop_ok;
  assign lvl   = wp_q - rp_q;
  assign full  = lvl == {1'b1, {A{1'b0}}};
  assign empty = lvl == '0;
  assign rd    = rd_q;
  // A pop frees a slot in the same cycle, so a full FIFO still accepts a simultaneous push;
  // a push into an empty FIFO is never visible to a same-cycle pop.
  always_comb begin
    push_ok = push & (~full | pop);
    pop_ok  = pop & ~empty;
    wp_d    = wp_q + (A+1)'(push_ok);
    rp_d    = rp_q + (A+1)'(pop_ok);
    rd_d    = pop ? (empty ? '0 : mem[rp_q[A-1:0]]) : rd_q;
    ovf_set = push & full & ~pop;
    unf_set = pop & empty;
  end
  // pointer and hold register state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
      rd_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      rd_q <= rd_d;
    end
  end
  // sample storage, no reset needed since pointers gate every read
  always_ff @(posedge clk) begin
    if (push_ok) mem[wp_q[A-1:0]] <= wd;
  end
endmodule

// File: rtl/cic_tx_feeder.sv
// cic_tx_feeder: dual-channel transmit buffer feeding the time-multiplexed CIC interpolator input
module cic_tx_feeder #(
  parameter int DW = cic_pkg::DW,
  parameter int AW = cic_pkg::AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr,
  input  logic          wch,
  input  logic [DW-1:0] wdx,
  input  logic [DW-1:0] wdy,
  output logic          fulla,
  output logic          fullb,
  output logic [AW:0]   lvla,
  output logic [AW:0]   lvlb,
  input  logic          tiea,
  input  logic          tieb,
  input  logic          ab,
  input  logic          c,
  output logic [DW-1:0] tdix,
  output logic [DW-1:0] tdiy,
  output logic          unfa,
  output logic          unfb,
  output logic          ovfa,
  output logic          ovfb,
  input  logic          clr
);
  logic [2*DW-1:0] ha, hb, tdi_q, tdi_d;
  logic [3:0]      flg_q, flg_d;
  logic            push_a, push_b, pop_b;
  logic            ovs_a, ovs_b, uns_a, uns_b;
  assign push_a = wr & (wch == cic_pkg::CH_A);
  assign push_b = wr & (wch == cic_pkg::CH_B) & c;
  assign pop_b  = tieb & c;
  tx_fifo #(.W(2*DW), .A(AW)) u_fa (
    .clk(clk), .rst(rst), .push(push_a), .pop(tiea), .wd({wdx, wdy}), .rd(ha),
    .lvl(lvla), .full(fulla), .ovf_set(ovs_a), .unf_set(uns_a)
  );
  tx_fifo #(.W(2*DW), .A(AW)) u_fb (
    .clk(clk), .rst(rst), .push(push_b), .pop(pop_b), .wd({wdx, wdy}), .rd(hb),
    .lvl(lvlb), .full(fullb), .ovf_set(ovs_b), .unf_set(uns_b)
  );
  assign {tdix, tdiy}             = tdi_q;
  assign {unfa, unfb, ovfa, ovfb} = flg_q;
  // output mux follows the channel phase, single-channel mode always shows A; new events beat clr
  always_comb begin
    tdi_d = (~c | (ab == cic_pkg::CH_A)) ? ha : hb;
    flg_d = (flg_q & ~{4{clr}}) | {uns_a, uns_b, ovs_a, ovs_b};
  end
  // output and sticky flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tdi_q <= '0;
      flg_q <= '0;
    end else begin
      tdi_q <= tdi_d;
      flg_q <= flg_d;
    end
  end
endmodule

// File: tb/tb_cic_tx_feeder.sv
// tb_cic_tx_feeder: scoreboard bench against a queue-based model of the transmit buffer
module tb_cic_tx_feeder;
  localparam int DW = 18;
  localparam int AW = 4;
  localparam int DEPTH = 1 << AW;
  typedef struct {
    logic [DW-1:0] x, y;
    logic [AW:0]   la, lb;
    logic          fa, fb;
    logic [3:0]    fl;
  } exp_t;
  logic clk = 0, rst = 1;
  logic wr = 0, wch = 0, tiea = 0, tieb = 0, ab = 0, c = 0, clr = 0;
  logic [DW-1:0] wdx = 0, wdy = 0, tdix, tdiy;
  logic [AW:0] lvla, lvlb;
  logic fulla, fullb, unfa, unfb, ovfa, ovfb;
  int n_chk = 0, n_pass = 0;
  exp_t sb[$];
  logic [2*DW-1:0] qa[$], qb[$];
  logic [2*DW-1:0] m_ha = 0, m_hb = 0;
  logic [3:0] m_fl = 0;
  logic ab_r = 1, c_r = 1;
  logic [DW-1:0] v;
  cic_tx_feeder dut (
    .clk(clk), .rst(rst), .wr(wr), .wch(wch), .wdx(wdx), .wdy(wdy),
    .fulla(fulla), .fullb(fullb), .lvla(lvla), .lvlb(lvlb),
    .tiea(tiea), .tieb(tieb), .ab(ab), .c(c), .tdix(tdix), .tdiy(tdiy),
    .unfa(unfa), .unfb(unfb), .ovfa(ovfa), .ovfb(ovfb), .clr(clr)
  );
  always #5 clk = ~clk;
  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endfunction
  // one clock of stimulus; the model applies the clock edge and queues what the DUT must show after it
  task automatic step(input logic w, wc, input logic [DW-1:0] dx, dy, input logic ta, tbq, cl);
    exp_t e;
    logic [3:0] s;
    s = 0;
    wr = w; wch = wc; wdx = dx; wdy = dy; tiea = ta; tieb = tbq; clr = cl; ab = ab_r; c = c_r;
    {e.x, e.y} = (!c_r || ab_r) ? m_ha : m_hb;
    if (ta) begin
      if (qa.size() == 0) begin m_ha = 0; s[3] = 1; end
      else m_ha = qa.pop_front();
    end
    if (tbq && c_r) begin
      if (qb.size() == 0) begin m_hb = 0; s[2] = 1; end
      else m_hb = qb.pop_front();
    end
    if (w && wc) begin
      if (qa.size() < DEPTH) qa.push_back({dx, dy}); else s[1] = 1;
    end
    if (w && !wc && c_r) begin
      if (qb.size() < DEPTH) qb.push_back({dx, dy}); else s[0] = 1;
    end
    m_fl = (cl ? 4'b0 : m_fl) | s;
    e.la = (AW+1)'(qa.size());
    e.lb = (AW+1)'(qb.size());
    e.fa = qa.size() == DEPTH;
    e.fb = qb.size() == DEPTH;
    e.fl = m_fl;
    sb.push_back(e);
    @(negedge clk);
    ab_r = ~ab_r;
  endtask
  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0, 0, 0);
  endtask
  // monitor: compares every registered output against the oldest expectation just after each edge
  always @(posedge clk) begin : mon
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("tdix", tdix, e.x);
      chk("tdiy", tdiy, e.y);
      chk("lvla", lvla, e.la);
      chk("lvlb", lvlb, e.lb);
      chk("full", {fulla, fullb}, {e.fa, e.fb});
      chk("flags", {unfa, unfb, ovfa, ovfb}, e.fl);
    end
  end
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_lvl", {lvla, lvlb}, 0);
    chk("rst_full", {fulla, fullb}, 0);
    chk("rst_tdi", {tdix, tdiy}, 0);
    chk("rst_flags", {unfa, unfb, ovfa, ovfb}, 0);
    rst = 0;
    for (int i = 1; i <= 3; i++) begin
      v = DW'(i);
      step(1, 1, v, -v, 0, 0, 0);
    end
    step(0, 0, 0, 0, 1, 0, 0);
    idle(4);
    chk("t1_lvla", lvla, 2);
    chk("t1_ha_x", dut.u_fa.rd_q[2*DW-1:DW], 1);
    step(1, 0, 18'h1FFFF, 18'h20000, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    idle(4);
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    step(1, 1, 18'd77, 18'd78, 1, 0, 0);
    idle(3);
    chk("t3_unfa", unfa, 1);
    chk("t3_lvla", lvla, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("t3_clr", unfa, 0);
    for (int i = 0; i < 16; i++) step(1, 1, DW'($urandom), DW'($urandom), 0, 0, 0);
    chk("t4_full", fulla, 1);
    chk("t4_ovfa", ovfa, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    step(1, 1, 18'd5, 18'd6, 1, 0, 0);
    chk("t4_lvl16", lvla, 16);
    chk("t4_noovf", ovfa, 0);
    c_r = 0;
    step(1, 0, 18'd9, 18'd9, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    idle(4);
    chk("t5_lvlb", lvlb, 0);
    chk("t5_flags", {unfb, ovfb}, 0);
    c_r = 1;
    repeat (11) step(0, 0, 0, 0, 1, 0, 0);
    chk("t6_lvla5", lvla, 5);
    #2 rst = 1;
    #1;
    chk("t6_rst_lvl", {lvla, lvlb, fulla, fullb}, 0);
    chk("t6_rst_tdi", {tdix, tdiy}, 0);
    chk("t6_rst_flags", {unfa, unfb, ovfa, ovfb}, 0);
    qa.delete(); qb.delete(); m_ha = 0; m_hb = 0; m_fl = 0;
    @(negedge clk);
    rst = 0;
    step(0, 0, 0, 0, 1, 0, 0);
    chk("t6_unfa", unfa, 1);
    for (int i = 0; i < 600; i++) begin
      if (i % 150 == 0) c_r = logic'($urandom_range(0, 1));
      step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, DW'($urandom), DW'($urandom),
           $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0);
    end
    repeat (2) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
